// File: rtl/board_arbiter_pkg.sv
// enum_type: board geometry, game op codes and arbiter FSM states shared by display and game logic.
package enum_type;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int KIND_W = 4;
  localparam int CELLS = BOARD_W * BOARD_H;
  localparam logic [4:0] W5 = 5'(BOARD_W);
  localparam logic [4:0] H5 = 5'(BOARD_H);
  localparam logic [7:0] LAST_CELL = 8'(CELLS - 1);
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_CLEAR, OP_DROP} op_t;
  typedef enum logic [3:0] {INIT_CLR, IDLE, GAP, RD, WR, CLR, DROP_RD, DROP_WR, DROP_TOP} state_t;
  function automatic logic [7:0] cell_addr(input logic [4:0] y, input logic [4:0] x);
    return 8'({3'b0, y} * 8'(BOARD_W) + {3'b0, x});
  endfunction
endpackage

// File: rtl/board_ram.sv
// board_ram: single-port board cell store, synchronous read, old data on read-during-write.
module board_ram import enum_type::*; (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [KIND_W-1:0] wdata,
  output logic [KIND_W-1:0] rdata
);
  logic [KIND_W-1:0] mem [CELLS];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/board_arbiter.sv
// board_arbiter: shares the board RAM port between display lookups and sequenced game commands.
module board_arbiter import enum_type::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_en,
  input  logic [4:0]        disp_x,
  input  logic [4:0]        disp_y,
  output logic [KIND_W-1:0] disp_kind,
  input  logic              gl_req,
  input  logic [1:0]        gl_op,
  input  logic [4:0]        gl_x,
  input  logic [4:0]        gl_y,
  input  logic [KIND_W-1:0] gl_wdata,
  output logic              gl_ack,
  output logic [KIND_W-1:0] gl_rdata,
  output logic              busy
);
  state_t state;
  logic [7:0] cnt, f_addr, ram_addr;
  logic [4:0] row, col;
  logic [KIND_W-1:0] ram_q, disp_r, rdata_r, hold, f_wdata;
  logic disp_q, rd_q, drop_q, f_en, f_we, ram_en, ram_we, free, disp_ok, gl_ok;
  assign free = !disp_en;
  assign disp_ok = disp_x < W5 && disp_y < H5;
  assign gl_ok = gl_x < W5 && gl_y < H5;
  always_comb begin
    f_en = state inside {RD, WR, CLR, INIT_CLR, DROP_RD, DROP_WR, DROP_TOP};
    f_we = state inside {WR, CLR, INIT_CLR, DROP_WR, DROP_TOP};
    f_addr = (state inside {CLR, INIT_CLR}) ? cnt :
             state == DROP_RD ? cell_addr(row - 5'd1, col) :
             state == DROP_WR ? cell_addr(row, col) :
             state == DROP_TOP ? cell_addr(5'd0, col) : cell_addr(gl_y, gl_x);
    f_wdata = state == WR ? gl_wdata : state == DROP_WR ? (drop_q ? ram_q : hold) : '0;
  end
  assign ram_en = disp_en ? disp_ok : f_en;
  assign ram_we = free && f_we;
  assign ram_addr = disp_en ? cell_addr(disp_y, disp_x) : f_addr;
  board_ram u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(f_wdata),
    .rdata(ram_q)
  );
  // RAM output is only trusted the cycle after its own read; otherwise the captured copy holds.
  always_ff @(posedge clk)
    if (reset) begin
      disp_q <= 1'b0;
      disp_r <= '0;
    end else begin
      disp_q <= disp_en && disp_ok;
      disp_r <= disp_en && !disp_ok ? '0 : disp_q ? ram_q : disp_r;
    end
  assign disp_kind = disp_q ? ram_q : disp_r;
  assign gl_rdata = rd_q ? ram_q : rdata_r;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_CLR;
      cnt <= '0;
      row <= '0;
      col <= '0;
      gl_ack <= 1'b0;
      rd_q <= 1'b0;
      drop_q <= 1'b0;
      rdata_r <= '0;
      hold <= '0;
    end else begin
      gl_ack <= 1'b0;
      rd_q <= 1'b0;
      drop_q <= free && state == DROP_RD;
      if (drop_q) hold <= ram_q;
      if (rd_q) rdata_r <= ram_q;
      case (state)
        INIT_CLR, CLR: if (free) begin
          cnt <= cnt == LAST_CELL ? '0 : cnt + 8'd1;
          if (cnt == LAST_CELL) begin
            gl_ack <= state == CLR;
            state <= state == CLR ? GAP : IDLE;
          end
        end
        IDLE: if (gl_req) begin
          row <= gl_y;
          col <= '0;
          if (gl_op == OP_CLEAR) state <= CLR;
          else if (gl_op == OP_DROP ? gl_y >= H5 : !gl_ok) begin
            gl_ack <= 1'b1;
            state <= GAP;
            if (gl_op == OP_READ) rdata_r <= '0;
          end else state <= gl_op == OP_READ ? RD : gl_op == OP_WRITE ? WR : gl_y == 5'd0 ? DROP_TOP : DROP_RD;
        end
        RD, WR: if (free) begin
          gl_ack <= 1'b1;
          rd_q <= state == RD;
          state <= GAP;
        end
        DROP_RD: if (free) state <= DROP_WR;
        DROP_WR: if (free) begin
          col <= col == W5 - 5'd1 ? '0 : col + 5'd1;
          if (col == W5 - 5'd1) row <= row - 5'd1;
          state <= col == W5 - 5'd1 && row == 5'd1 ? DROP_TOP : DROP_RD;
        end
        DROP_TOP: if (free) begin
          col <= col + 5'd1;
          if (col == W5 - 5'd1) begin
            gl_ack <= 1'b1;
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
